// File: rtl/writeback_stage_pkg.sv
// Shared encodings and widths for the writeback stage: write-back source
// select, load funct3 codes, and the load alignment helper.
package writeback_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_RSV = 3'b111
  } ld_f3_e;

  // The reserved encoding behaves like ld, so it needs full doubleword alignment.
  function automatic logic ld_misaligned(ld_f3_e f3, logic [2:0] addr_lo);
    case (f3)
      F3_LB, F3_LBU: ld_misaligned = 1'b0;
      F3_LH, F3_LHU: ld_misaligned = addr_lo[0];
      F3_LW, F3_LWU: ld_misaligned = |addr_lo[1:0];
      default:       ld_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB input bundle and register-file write / forwarding outputs.
// master = MEM stage + register file side, slave = writeback stage.
interface writeback_stage_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   mem_rdata;
  logic [XLEN-1:0]   pc_plus4;
  logic [REG_AW-1:0] rd_in;
  logic              reg_write_in;
  logic [1:0]        wb_sel;
  logic [2:0]        load_funct3;
  logic [2:0]        addr_lo;

  logic              RegWrite;
  logic [REG_AW-1:0] RD;
  logic [XLEN-1:0]   WriteData;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;
  logic              load_misaligned;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output in_valid, stall, flush, alu_result, mem_rdata, pc_plus4,
           rd_in, reg_write_in, wb_sel, load_funct3, addr_lo,
    input  RegWrite, RD, WriteData, fwd_valid, fwd_rd, fwd_data,
           load_misaligned, retire_count
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, mem_rdata, pc_plus4,
           rd_in, reg_write_in, wb_sel, load_funct3, addr_lo,
    output RegWrite, RD, WriteData, fwd_valid, fwd_rd, fwd_data,
           load_misaligned, retire_count
  );
endinterface

// File: rtl/writeback_stage_load_extract.sv
// Combinational load extraction: picks the addressed byte/half/word/dword
// out of the aligned doubleword and sign- or zero-extends it.
module load_extract
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = writeback_stage_pkg::XLEN
) (
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [2:0]      load_funct3_i,
  input  logic [2:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  ld_f3_e      f3;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign f3 = ld_f3_e'(load_funct3_i);

  // Half/word lanes index by the upper address bits only, so a misaligned
  // access still reads its naturally aligned container.
  always_comb begin
    byte_v = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = mem_rdata_i[{addr_lo_i[2:1], 4'b0000} +: 16];
    word_v = mem_rdata_i[{addr_lo_i[2], 5'b00000} +: 32];
  end

  always_comb begin
    data_o = mem_rdata_i;
    case (f3)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   data_o = {{(XLEN-32){word_v[31]}}, word_v};
      F3_LWU:  data_o = {{(XLEN-32){1'b0}}, word_v};
      default: data_o = mem_rdata_i;
    endcase
  end

  assign misaligned_o = ld_misaligned(f3, addr_lo_i);

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback select. Outputs come straight from
// posedge flops so the register file sees them stable across its negedge write.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN   = writeback_stage_pkg::XLEN,
  parameter int REG_AW = writeback_stage_pkg::REG_AW,
  parameter int CNT_W  = writeback_stage_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  writeback_stage_if.slave wb
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              misaligned;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  wb_entry_t        ent_q, ent_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ld_data;
  logic             ld_mis;
  logic [XLEN-1:0]  sel_data;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .mem_rdata_i   (wb.mem_rdata),
    .load_funct3_i (wb.load_funct3),
    .addr_lo_i     (wb.addr_lo),
    .data_o        (ld_data),
    .misaligned_o  (ld_mis)
  );

  always_comb begin
    case (wb_sel_e'(wb.wb_sel))
      WB_MEM:  sel_data = ld_data;
      WB_PC4:  sel_data = wb.pc_plus4;
      default: sel_data = wb.alu_result;
    endcase
  end

  // Flush only kills the qualifiers; rd/data are don't-care once valid drops.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (wb.flush) begin
      ent_d.valid      = 1'b0;
      ent_d.reg_write  = 1'b0;
      ent_d.misaligned = 1'b0;
    end else if (!wb.stall) begin
      ent_d.valid      = wb.in_valid;
      ent_d.reg_write  = wb.reg_write_in;
      ent_d.rd         = wb.rd_in;
      ent_d.data       = sel_data;
      ent_d.misaligned = wb.in_valid & (wb_sel_e'(wb.wb_sel) == WB_MEM) & ld_mis;
      if (wb.in_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  logic we;
  assign we = ent_q.valid & ent_q.reg_write & (|ent_q.rd) & ~ent_q.misaligned;

  assign wb.RegWrite        = we;
  assign wb.RD              = ent_q.rd;
  assign wb.WriteData       = ent_q.data;
  assign wb.fwd_valid       = we;
  assign wb.fwd_rd          = ent_q.rd;
  assign wb.fwd_data        = ent_q.data;
  assign wb.load_misaligned = ent_q.misaligned;
  assign wb.retire_count    = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, stall/flush
// and async reset sequences, then randomized traffic against a reference model.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(64), .REG_AW(5), .CNT_W(32)) ifc ();

  writeback_stage #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (ifc.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_valid, m_rw, m_mis;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [31:0] m_cnt;

  localparam logic [63:0] MEM = 64'h80FF_0000_8000_00F0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ld_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  // Load value from size/offset arithmetic: shift, mask, then sign-fill.
  function automatic logic [63:0] ref_load(input logic [63:0] m, input logic [2:0] f3,
                                           input logic [2:0] a);
    int sz;
    int off;
    logic [63:0] v, mask;
    sz   = ld_size(f3);
    off  = (int'(a) / sz) * sz;
    v    = m >> (off * 8);
    mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (sz * 8)) - 64'd1);
    v    = v & mask;
    if (f3 < 3'd3 && v[sz*8-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mis = 0; m_rd = '0; m_data = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    if (ifc.flush) begin
      m_valid = 0; m_rw = 0; m_mis = 0;
    end else if (!ifc.stall) begin
      m_valid = ifc.in_valid;
      m_rw    = ifc.reg_write_in;
      m_rd    = ifc.rd_in;
      case (ifc.wb_sel)
        2'b01:   m_data = ref_load(ifc.mem_rdata, ifc.load_funct3, ifc.addr_lo);
        2'b10:   m_data = ifc.pc_plus4;
        default: m_data = ifc.alu_result;
      endcase
      m_mis = ifc.in_valid && ifc.wb_sel == 2'b01 &&
              (int'(ifc.addr_lo) % ld_size(ifc.load_funct3)) != 0;
      if (ifc.in_valid) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_we;
    exp_we = m_valid && m_rw && (m_rd != 0) && !m_mis;
    chk({tag, ".RegWrite"},  64'(ifc.RegWrite),  64'(exp_we));
    chk({tag, ".fwd_valid"}, 64'(ifc.fwd_valid), 64'(exp_we));
    chk({tag, ".misalign"},  64'(ifc.load_misaligned), 64'(m_mis));
    chk({tag, ".retire"},    64'(ifc.retire_count), 64'(m_cnt));
    if (m_valid) begin
      chk({tag, ".RD"},        64'(ifc.RD),     64'(m_rd));
      chk({tag, ".fwd_rd"},    64'(ifc.fwd_rd), 64'(m_rd));
      chk({tag, ".WriteData"}, ifc.WriteData,   m_data);
      chk({tag, ".fwd_data"},  ifc.fwd_data,    m_data);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [2:0] a, input logic [63:0] alu,
                       input logic [63:0] mem, input logic [63:0] pc4, input logic [4:0] rd,
                       input logic rw);
    ifc.in_valid = v; ifc.stall = st; ifc.flush = fl; ifc.wb_sel = sel;
    ifc.load_funct3 = f3; ifc.addr_lo = a; ifc.alu_result = alu; ifc.mem_rdata = mem;
    ifc.pc_plus4 = pc4; ifc.rd_in = rd; ifc.reg_write_in = rw;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_we;
    logic [63:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{"alu",      2'b00, 3'd0, 3'd0, 64'h1234, 64'h0,   5'd5,  1'b1, 1'b1, 64'h1234, 1'b0};
    vt[1]  = '{"lb0",      2'b01, 3'd0, 3'd0, 64'h0,    64'h0,   5'd3,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0};
    vt[2]  = '{"lbu0",     2'b01, 3'd4, 3'd0, 64'h0,    64'h0,   5'd3,  1'b1, 1'b1, 64'h0000_0000_0000_00F0, 1'b0};
    vt[3]  = '{"lh6",      2'b01, 3'd1, 3'd6, 64'h0,    64'h0,   5'd3,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_80FF, 1'b0};
    vt[4]  = '{"lwu4",     2'b01, 3'd6, 3'd4, 64'h0,    64'h0,   5'd3,  1'b1, 1'b1, 64'h0000_0000_80FF_0000, 1'b0};
    vt[5]  = '{"lw2_mis",  2'b01, 3'd2, 3'd2, 64'h0,    64'h0,   5'd3,  1'b1, 1'b0, 64'hFFFF_FFFF_8000_00F0, 1'b1};
    vt[6]  = '{"ld0",      2'b01, 3'd3, 3'd0, 64'h0,    64'h0,   5'd8,  1'b1, 1'b1, MEM, 1'b0};
    vt[7]  = '{"x0",       2'b00, 3'd0, 3'd0, 64'h55,   64'h0,   5'd0,  1'b1, 1'b0, 64'h55, 1'b0};
    vt[8]  = '{"jal",      2'b10, 3'd0, 3'd0, 64'h9,    64'h104, 5'd1,  1'b1, 1'b1, 64'h104, 1'b0};
    vt[9]  = '{"sel_rsv",  2'b11, 3'd0, 3'd0, 64'hABCD, 64'h8,   5'd9,  1'b1, 1'b1, 64'hABCD, 1'b0};
    vt[10] = '{"f3_rsv",   2'b01, 3'd7, 3'd0, 64'h0,    64'h0,   5'd10, 1'b1, 1'b1, MEM, 1'b0};
    vt[11] = '{"alu_nomis",2'b00, 3'd1, 3'd1, 64'h77,   64'h0,   5'd11, 1'b1, 1'b1, 64'h77, 1'b0};
    vt[12] = '{"no_rw",    2'b00, 3'd0, 3'd0, 64'h1,    64'h0,   5'd12, 1'b0, 1'b0, 64'h1, 1'b0};
    vt[13] = '{"lhu2",     2'b01, 3'd5, 3'd2, 64'h0,    64'h0,   5'd13, 1'b1, 1'b1, 64'h0000_0000_0000_8000, 1'b0};
    vt[14] = '{"lb7",      2'b01, 3'd0, 3'd7, 64'h0,    64'h0,   5'd14, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vt[15] = '{"lh3_mis",  2'b01, 3'd1, 3'd3, 64'h0,    64'h0,   5'd15, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8000, 1'b1};
    vt[16] = '{"ld4_mis",  2'b01, 3'd3, 3'd4, 64'h0,    64'h0,   5'd16, 1'b1, 1'b0, MEM, 1'b1};

    // Reset state
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 3'd0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.RD", 64'(ifc.RD), 64'h0);
    chk("reset.WriteData", ifc.WriteData, 64'h0);
    reset = 1'b1;

    // Directed vector table
    foreach (vt[i]) begin
      drive(1, 0, 0, vt[i].sel, vt[i].f3, vt[i].a, vt[i].alu, MEM, vt[i].pc4, vt[i].rd, vt[i].rw);
      cycle(vt[i].name);
      chk({vt[i].name, ".tbl_we"},   64'(ifc.RegWrite), 64'(vt[i].exp_we));
      chk({vt[i].name, ".tbl_rd"},   64'(ifc.RD),       64'(vt[i].rd));
      chk({vt[i].name, ".tbl_data"}, ifc.WriteData,     vt[i].exp_data);
      chk({vt[i].name, ".tbl_mis"},  64'(ifc.load_misaligned), 64'(vt[i].exp_mis));
    end
    chk("table.retire", 64'(ifc.retire_count), 64'd17);

    // Stall holds rd=7 for three cycles while inputs churn
    drive(1, 0, 0, 2'b00, 3'd0, 3'd0, 64'h7777, MEM, 64'h0, 5'd7, 1);
    cycle("cap7");
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 2'($urandom), 3'($urandom), 3'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1);
      cycle("stall");
      chk("stall.RD", 64'(ifc.RD), 64'd7);
      chk("stall.retire", 64'(ifc.retire_count), 64'd18);
    end

    // Misaligned flag persists through a stall
    drive(1, 0, 0, 2'b01, 3'd2, 3'd1, 64'h0, MEM, 64'h0, 5'd4, 1);
    cycle("mis_cap");
    drive(1, 1, 0, 2'b00, 3'd0, 3'd0, 64'h1, MEM, 64'h0, 5'd4, 1);
    cycle("mis_stall");
    chk("mis_stall.flag", 64'(ifc.load_misaligned), 64'd1);

    // Flush beats stall
    drive(1, 0, 0, 2'b00, 3'd0, 3'd0, 64'h42, MEM, 64'h0, 5'd6, 1);
    cycle("pre_flush");
    drive(1, 1, 1, 2'b00, 3'd0, 3'd0, 64'h43, MEM, 64'h0, 5'd6, 1);
    cycle("flush_stall");
    chk("flush_stall.we", 64'(ifc.RegWrite), 64'd0);
    chk("flush_stall.retire", 64'(ifc.retire_count), 64'd20);

    // Bubble: in_valid=0 writes nothing and is not counted
    drive(0, 0, 0, 2'b00, 3'd0, 3'd0, 64'h44, MEM, 64'h0, 5'd6, 1);
    cycle("bubble");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            2'($urandom), 3'($urandom), 3'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
      cycle("rand");
    end

    // Asynchronous reset mid-cycle while a write is pending
    drive(1, 0, 0, 2'b00, 3'd0, 3'd0, 64'h99, MEM, 64'h0, 5'd4, 1);
    cycle("pre_rst");
    chk("pre_rst.we", 64'(ifc.RegWrite), 64'd1);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async.we", 64'(ifc.RegWrite), 64'd0);
    chk("async.retire", 64'(ifc.retire_count), 64'd0);
    check_all("async");
    @(posedge clk);
    #1;
    check_all("in_rst");
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 3'd0, 3'd0, 64'h0, MEM, 64'h0, 5'd4, 1);
    cycle("post_rst");
    chk("post_rst.we", 64'(ifc.RegWrite), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Producer side of the 64-bit, 32-entry register file write port: MEM/WB pipeline register plus writeback select and load extraction.
- Drives RegWrite/RD/WriteData into the register file, which commits them on the falling clock edge.
- Outputs are registered on the rising edge, so they are stable for the whole negedge write window.
- Also exposes a WB-stage forwarding tap and a retire counter.

Parameters:
- XLEN, 64, data width of results and register file words
- REG_AW, 5, register address width (32 registers)
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  MEM stage holds a real instruction
- stall  in  1  hold the WB register contents
- flush  in  1  replace the captured entry with a bubble
- alu_result  in  XLEN  ALU result from MEM stage
- mem_rdata  in  XLEN  raw aligned doubleword from data memory
- pc_plus4  in  XLEN  link value for jal/jalr
- rd_in  in  REG_AW  destination register
- reg_write_in  in  1  instruction writes rd
- wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- load_funct3  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 reserved (treated as ld)
- addr_lo  in  3  alu_result[2:0] byte offset of the load
- RegWrite  out  1  register file write enable
- RD  out  REG_AW  register file write address
- WriteData  out  XLEN  register file write data
- fwd_valid  out  1  equals RegWrite; forwarding unit qualifier
- fwd_rd  out  REG_AW  equals RD
- fwd_data  out  XLEN  equals WriteData
- load_misaligned  out  1  captured load was misaligned; its write is suppressed
- retire_count  out  CNT_W  number of valid entries captured

Behaviour:
- Reset (reset=0, async): valid, reg_write, RD, WriteData, load_misaligned and retire_count all clear to 0. RegWrite=0 immediately, without waiting for a clock edge.
- Capture rule at posedge, in priority order:
  - flush=1: valid<=0, reg_write<=0, load_misaligned<=0. Flush wins over stall.
  - else stall=1: all registers hold their values.
  - else: capture in_valid, rd_in, reg_write_in, the selected/extracted data, and the misaligned flag.
- Latency: exactly one cycle from MEM inputs to RegWrite/RD/WriteData. Register file contents update at the following negedge.
- Load extraction (combinational, before the register):
  - lb/lbu: byte at addr_lo.
  - lh/lhu: halfword at addr_lo[2:1].
  - lw/lwu: word at addr_lo[2].
  - ld: whole doubleword.
  - Signed variants sign-extend to XLEN; unsigned variants zero-extend.
- Misalignment applies only when wb_sel=01:
  - lh/lhu misaligned if addr_lo[0]=1.
  - lw/lwu misaligned if addr_lo[1:0]!=0.
  - ld misaligned if addr_lo!=0.
- RegWrite = valid & reg_write & (RD!=0) & ~load_misaligned. Writes to x0 never reach the register file.
- load_misaligned is asserted only when valid=1, and stays asserted while the entry is held by stall.
- retire_count increments by 1 on each capture with in_valid=1 (not flushed, not stalled). It wraps modulo 2^CNT_W, and held entries are not recounted.
- Reset mid-operation: the in-flight entry is discarded and no write is issued.

Decomposition:
- Shared package holds:
  - wb_sel encodings: WB_ALU, WB_MEM, WB_PC4.
  - funct3 load encodings: F3_LB..F3_LWU.
  - XLEN and REG_AW constants.
- One sub-module, load_extract: combinational; inputs mem_rdata, load_funct3, addr_lo; outputs extended data and misaligned flag.

Test Plan:
- Reset, then ALU op (alu_result=0x1234, rd_in=5, wb_sel=00) -> next cycle RegWrite=1, RD=5, WriteData=0x1234, retire_count=1.
- Load sign/zero extension with mem_rdata=0x80FF_0000_8000_00F0:
  - lb, addr_lo=0 -> WriteData=0xFFFF_FFFF_FFFF_FFF0.
  - lbu, addr_lo=0 -> 0xF0.
  - lh, addr_lo=6 -> 0xFFFF_FFFF_FFFF_80FF.
  - lwu, addr_lo=4 -> 0x80FF_0000.
- lw with addr_lo=2 -> load_misaligned=1, RegWrite=0. A following aligned ld clears load_misaligned.
- rd_in=0, reg_write_in=1 -> RegWrite=0 and retire_count still increments. jal with pc_plus4=0x104, rd_in=1 -> WriteData=0x104.
- Stall and flush:
  - Capture rd=7, then stall=1 for 3 cycles while inputs change -> RD=7 held, retire_count unchanged.
  - flush=1 together with stall=1 -> RegWrite=0 the next cycle.
- Assert reset=0 asynchronously mid-cycle while RegWrite=1 -> RegWrite drops to 0 before the next edge and retire_count=0.
